// File: rtl/padded_fmap_reader_pkg.sv
// Shared definitions for the padded feature-map reader (and its matching padding writer):
// FSM state encoding, default address stride, word-count width and the frame-size helper.
package padded_fmap_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int ADDR_STEP_DEF = 4;
  localparam int WCNT_W        = 24;

  // Words in one padded frame: Wp*Wp*(C/PE), Wp = W + 2*pad, kept to WCNT_W bits.
  function automatic logic [WCNT_W-1:0] frame_words(input logic [7:0] ifm_c,
                                                    input logic [7:0] ifm_w,
                                                    input logic       pad,
                                                    input logic [7:0] pe);
    logic [WCNT_W-1:0] wp;
    logic [WCNT_W-1:0] cw;
    wp = WCNT_W'(ifm_w) + (pad ? WCNT_W'(2) : WCNT_W'(0));
    cw = WCNT_W'(ifm_c / pe);
    return wp * wp * cw;
  endfunction

endpackage

// File: rtl/padded_fmap_reader_skid_fifo.sv
// reader_skid_fifo: two-entry FIFO that catches buffer read returns so the reader
// can tolerate downstream backpressure; head is presented directly on the output.
module reader_skid_fifo #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  // Occupancy follows push/pop; simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 2'd1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 2'd1;
  end

  // Storage and pointers; cleared on reset so the output word reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = cnt_q;

endmodule

// File: rtl/padded_fmap_reader.sv
// padded_fmap_reader: streams a padded feature map out of the activation buffer in
// raster order (channel word, column, row), keeping at most two words outstanding.
// Optional build macro PADDED_READER_STALL_CNT_EN adds a saturating stall counter output.
module padded_fmap_reader
  import padded_fmap_reader_pkg::*;
#(
  parameter int PE        = 16,
  parameter int ADDR_STEP = ADDR_STEP_DEF,
  parameter int RD_LAT    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      IFM_C,
  input  logic [7:0]      IFM_W,
  input  logic            padding,
  output logic            rd_en,
  output logic [15:0]     rd_addr,
  input  logic [PE*8-1:0] rd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PE*8-1:0] out_data,
  output logic            out_last,
  output logic            busy,
  output logic            done
`ifdef PADDED_READER_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] n_calc;
  logic [WCNT_W-1:0] n_q;
  logic [WCNT_W-1:0] issued_q, issued_d;
  logic [WCNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [15:0]       addr_q, addr_d;
  logic [1:0]        rd_vld_q, rd_vld_d;
  logic [1:0]        inflight;
  logic [1:0]        fifo_cnt;
  logic              accept;
  logic              pop;
  logic              push;

  assign n_calc = frame_words(IFM_C, IFM_W, padding, 8'(PE));
  assign accept = (state_q == IDLE) && start;

  // Read strobes travel down a short shift register that marks when rd_data is valid.
  assign rd_vld_d = {(RD_LAT == 2) ? rd_vld_q[0] : 1'b0, rd_en};
  assign push     = rd_vld_q[RD_LAT-1];
  assign inflight = {1'b0, rd_vld_q[0]} + {1'b0, rd_vld_q[1]};

  // Issue only while FIFO contents plus reads in flight stay below two.
  assign rd_en = (state_q == READ) && (({1'b0, fifo_cnt} + {1'b0, inflight}) < 3'd2);

  reader_skid_fifo #(.W(PE*8)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (rd_data),
    .pop_i       (pop),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .count_o     (fifo_cnt)
  );

  assign pop      = out_valid && out_ready;
  assign out_last = out_valid && (out_cnt_q == n_q - 24'd1);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign rd_addr  = addr_q;

  // Next-state logic: frame sequencing from start through drain to the done pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (n_calc == '0) ? FINISH : READ;
      READ:    if (rd_en && (issued_q == n_q - 24'd1)) state_d = DRAIN;
      DRAIN:   if (pop && out_last) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and word counters restart on an accepted start and advance per read/transfer.
  always_comb begin
    addr_d    = addr_q;
    issued_d  = issued_q;
    out_cnt_d = out_cnt_q;
    if (accept) begin
      addr_d    = 16'd0;
      issued_d  = '0;
      out_cnt_d = '0;
    end else begin
      if (rd_en) begin
        addr_d   = addr_q + 16'(ADDR_STEP);
        issued_d = issued_q + 24'd1;
      end
      if (pop) out_cnt_d = out_cnt_q + 24'd1;
    end
  end

  // Control and counter registers; reset aborts the frame and forgets in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      issued_q  <= '0;
      out_cnt_q <= '0;
      addr_q    <= 16'd0;
      rd_vld_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      out_cnt_q <= out_cnt_d;
      addr_q    <= addr_d;
      rd_vld_q  <= rd_vld_d;
      if (accept) n_q <= n_calc;
    end
  end

`ifdef PADDED_READER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Stall counter: cycles where a word waits on downstream, saturating at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (accept)                                        stall_d = 16'd0;
    else if (out_valid && !out_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= 16'd0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_padded_fmap_reader.sv
// Self-checking bench for padded_fmap_reader: a buffer model answers reads, a
// scoreboard queue holds the word expected for every issued read.
module tb_padded_fmap_reader;

  localparam int PE        = 16;
  localparam int ADDR_STEP = 4;
  localparam int RD_LAT    = 1;
  localparam int W         = PE * 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [7:0]    IFM_C;
  logic [7:0]    IFM_W;
  logic          padding;
  logic          rd_en;
  logic [15:0]   rd_addr;
  logic [W-1:0]  rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef PADDED_READER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int checks;
  int errors;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t sb[$];

  padded_fmap_reader #(.PE(PE), .ADDR_STEP(ADDR_STEP), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .IFM_C     (IFM_C),
    .IFM_W     (IFM_W),
    .padding   (padding),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef PADDED_READER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [W-1:0] mk_word(input logic [15:0] a);
    logic [W-1:0] r;
    for (int i = 0; i < PE; i++) r[i*8 +: 8] = a[9:2] ^ 8'(i * 37);
    return r;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model with one cycle of read latency.
  always @(posedge clk) if (rd_en) rd_data <= mk_word(rd_addr);

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string name);
    checks++;
    if (rd_en !== 1'b0 || rd_addr !== 16'd0 || out_valid !== 1'b0 || out_data !== '0 ||
        out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s rd_en=%b rd_addr=%0d out_valid=%b out_last=%b busy=%b done=%b out_data=%h required all zero",
               name, rd_en, rd_addr, out_valid, out_last, busy, done, out_data);
    end
`ifdef PADDED_READER_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s_stall_cnt got %0d required 0", name, stall_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; IFM_C = 8'd0; IFM_W = 8'd0; padding = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ready_mode: 0 always ready, 1 low in [st_lo,st_hi], 2 random.
  task automatic run_frame(input string name, input logic [7:0] c, input logic [7:0] w,
                           input logic pad, input int exp_n, input int ready_mode,
                           input int st_lo, input int st_hi, input int restart_cyc,
                           input int abort_at, input int exp_stall);
    int   cyc, issued, accepted, acc0, done_cnt, done_cyc, max_out, cur_out;
    bit   finished;
    logic exp_busy;
    exp_t e;
    sb.delete();
    issued = 0; accepted = 0; done_cnt = 0; done_cyc = -1; max_out = 0; finished = 0; cyc = 0;
    @(negedge clk);
    while (!finished && cyc < 500) begin
      start   = (cyc == 0) || (cyc == restart_cyc);
      IFM_C   = c;
      padding = pad;
      IFM_W   = (cyc == restart_cyc) ? 8'd5 : w;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= st_lo && cyc <= st_hi);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      exp_busy = (cyc >= 1) && (done_cyc < 0);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy cycle %0d got %b required %b", name, cyc, busy, exp_busy);
      end
      acc0 = accepted;
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_word cycle %0d data %h with nothing outstanding", name, cyc, out_data);
        end else begin
          if (out_data !== sb[0].data || out_last !== sb[0].last) begin
            errors++;
            $display("FAIL %s word %0d got data %h last %b required data %h last %b",
                     name, accepted, out_data, out_last, sb[0].data, sb[0].last);
          end
          if (out_ready) begin
            void'(sb.pop_front());
            accepted++;
          end
        end
      end
      if (rd_en) begin
        checks++;
        if (rd_addr !== 16'(issued * ADDR_STEP) || issued >= exp_n) begin
          errors++;
          $display("FAIL %s read %0d got addr %0d required addr %0d of %0d reads",
                   name, issued, rd_addr, issued * ADDR_STEP, exp_n);
        end
        e.data = mk_word(16'(issued * ADDR_STEP));
        e.last = (issued == exp_n - 1);
        sb.push_back(e);
        issued++;
      end
      cur_out = issued - acc0;
      if (cur_out > max_out) max_out = cur_out;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL %s done_width got done=%b required 0 one cycle after pulse", name, done);
        end
        finished = 1;
      end else if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        checks++;
        if (accepted != exp_n) begin
          errors++;
          $display("FAIL %s done_early got %0d words accepted required %0d", name, accepted, exp_n);
        end
      end
      if (abort_at >= 0 && accepted == abort_at) finished = 1;
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout got %0d words required %0d", name, accepted, exp_n);
    end
    if (abort_at < 0) begin
      checks++;
      if (issued != exp_n || accepted != exp_n || done_cnt != 1 || sb.size() != 0) begin
        errors++;
        $display("FAIL %s totals got reads %0d words %0d dones %0d left %0d required %0d %0d 1 0",
                 name, issued, accepted, done_cnt, sb.size(), exp_n, exp_n);
      end
      checks++;
      if (max_out > 2) begin
        errors++;
        $display("FAIL %s outstanding got %0d required at most 2", name, max_out);
      end
      if (exp_n == 0) begin
        checks++;
        if (done_cyc < 1 || done_cyc > 2) begin
          errors++;
          $display("FAIL %s done_latency got cycle %0d required 1..2", name, done_cyc);
        end
      end
`ifdef PADDED_READER_STALL_CNT_EN
      if (exp_stall >= 0) begin
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
          errors++;
          $display("FAIL %s stall_cnt got %0d required %0d", name, stall_cnt, exp_stall);
        end
      end
`endif
    end
  endtask

  task automatic test_basic_padded();
    run_frame("padded_16", 8'd16, 8'd2, 1'b1, 16, 0, 0, 0, -1, -1, 0);
  endtask

  task automatic test_unpadded_multi_ch();
    run_frame("unpadded_18", 8'd32, 8'd3, 1'b0, 18, 0, 0, 0, -1, -1, 0);
  endtask

  task automatic test_backpressure();
    run_frame("stall_3_8", 8'd16, 8'd2, 1'b1, 16, 1, 3, 8, -1, -1, 6);
  endtask

  task automatic test_zero_width();
    run_frame("zero_width", 8'd16, 8'd0, 1'b0, 0, 0, 0, 0, -1, -1, -1);
  endtask

  task automatic test_start_while_busy();
    run_frame("restart_ignored", 8'd16, 8'd2, 1'b1, 16, 0, 0, 0, 4, -1, 0);
  endtask

  task automatic test_random_ready();
    run_frame("random_ready", 8'd32, 8'd1, 1'b1, 18, 2, 0, 0, -1, -1, -1);
  endtask

  task automatic test_abort();
    run_frame("abort_at_7", 8'd16, 8'd2, 1'b1, 16, 0, 0, 0, -1, 7, -1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_reset_state");
    @(negedge clk);
    #1;
    check_reset_outputs("abort_reset_held");
    rst_n = 1'b1;
    run_frame("after_abort", 8'd16, 8'd2, 1'b1, 16, 0, 0, 0, -1, -1, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_padded();
    test_unpadded_multi_ch();
    test_backpressure();
    test_zero_width();
    test_start_while_busy();
    test_random_ready();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
